// File: rtl/sprite_list_buffer.sv
// sprite_list_buffer
//   Double-buffered sprite list sitting between the sprite processor and the
//   graphics stage. While one bank collects the processor's sprite stream for
//   the current video frame, the other bank replays the list captured during
//   the previous frame to the renderer over a valid/ready handshake. Banks swap
//   on every new_frame pulse.
//
// Ports
//   clk_pixel    in   pixel clock (only clock)
//   sys_rst_n    in   synchronous active-low reset
//   new_frame    in   one-cycle frame pulse; swaps banks, restarts replay
//   in_valid     in   sprite strobe from the processor (no backpressure)
//   in_x/in_y/in_frame   in   sprite coordinates and animation frame
//   out_valid    out  replay entry available
//   out_ready    in   graphics accepts the entry
//   out_x/out_y/out_frame out  replayed entry
//   out_last     out  marks the final entry of the list
//   wr_count     out  entries captured so far this frame
//   replay_done  out  read bank fully drained (or empty)
//   overflow     out  a write was dropped this collection frame
//   underrun     out  sticky: a replay was cut short by new_frame
module sprite_list_buffer #(
   parameter int CANVAS_WIDTH  = 360,
   parameter int CANVAS_HEIGHT = 720,
   parameter int NUM_FRAMES    = 5,
   parameter int MAX_SPRITES   = 64,
   localparam int XW = $clog2(CANVAS_WIDTH),
   localparam int YW = $clog2(CANVAS_HEIGHT),
   localparam int FW = $clog2(NUM_FRAMES),
   localparam int CW = $clog2(MAX_SPRITES + 1)
) (
   input  logic          clk_pixel,
   input  logic          sys_rst_n,
   input  logic          new_frame,
   input  logic          in_valid,
   input  logic [XW-1:0] in_x,
   input  logic [YW-1:0] in_y,
   input  logic [FW-1:0] in_frame,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [XW-1:0] out_x,
   output logic [YW-1:0] out_y,
   output logic [FW-1:0] out_frame,
   output logic          out_last,
   output logic [CW-1:0] wr_count,
   output logic          replay_done,
   output logic          overflow,
   output logic          underrun
);

   localparam int DW = XW + YW + FW;
   localparam int MW = $clog2(2 * MAX_SPRITES);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FETCH   = 2'd1;
   localparam logic [1:0] ST_PRESENT = 2'd2;

   // Both banks live in one array: bank A at [0, MAX), bank B at [MAX, 2*MAX).
   logic [DW-1:0] mem [0:2*MAX_SPRITES-1];

   logic          wsel_reg;
   logic [CW-1:0] wr_count_reg;
   logic          overflow_reg;

   logic [1:0]    state_reg;
   logic [CW-1:0] rd_len_reg;
   logic [CW-1:0] rd_ptr_reg;
   logic          out_valid_reg;
   logic          out_last_reg;
   logic          replay_done_reg;
   logic          underrun_reg;
   logic [DW-1:0] rd_data_reg;

   // ------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------
   logic          wr_full;
   logic          wr_en;
   logic          wr_bank;
   logic [CW-1:0] wr_idx;
   logic [MW-1:0] waddr;

   // A write coincident with new_frame lands at index 0 of the bank that is
   // about to become the write bank, so it can never be dropped.
   assign wr_full = (wr_count_reg == CW'(MAX_SPRITES));
   assign wr_en   = in_valid && (new_frame || !wr_full);
   assign wr_bank = new_frame ? ~wsel_reg : wsel_reg;
   assign wr_idx  = new_frame ? '0 : wr_count_reg;
   assign waddr   = (wr_bank ? MW'(MAX_SPRITES) : MW'(0)) + MW'(wr_idx);

   always_ff @(posedge clk_pixel) begin
      if (wr_en) begin
         mem[waddr] <= {in_x, in_y, in_frame};
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (!sys_rst_n) begin
         wsel_reg     <= 1'b0;
         wr_count_reg <= '0;
         overflow_reg <= 1'b0;
      end else if (new_frame) begin
         wsel_reg     <= ~wsel_reg;
         wr_count_reg <= in_valid ? CW'(1) : '0;
         overflow_reg <= 1'b0;
      end else if (in_valid) begin
         if (!wr_full) begin
            wr_count_reg <= wr_count_reg + CW'(1);
         end else begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read side / replay
   // ------------------------------------------------------------------
   // The RAM output register doubles as the output data register. A read is
   // issued only when the presented entry is consumed (or at list start), so
   // the data holds still during stalls and back-to-back transfers need no
   // extra skid stage: the next entry is read on the same edge as the transfer.
   logic          xfer;
   logic          at_last;
   logic          rd_en;
   logic [CW-1:0] rd_idx;
   logic [MW-1:0] raddr;

   assign xfer    = out_valid_reg && out_ready;
   assign at_last = (rd_ptr_reg == rd_len_reg - CW'(1));
   assign rd_en   = !new_frame &&
                    ((state_reg == ST_FETCH) ||
                     ((state_reg == ST_PRESENT) && xfer && !at_last));
   assign rd_idx  = (state_reg == ST_FETCH) ? rd_ptr_reg : rd_ptr_reg + CW'(1);
   assign raddr   = (wsel_reg ? MW'(0) : MW'(MAX_SPRITES)) + MW'(rd_idx);

   always_ff @(posedge clk_pixel) begin
      if (!sys_rst_n) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= mem[raddr];
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (!sys_rst_n) begin
         state_reg       <= ST_IDLE;
         rd_len_reg      <= '0;
         rd_ptr_reg      <= '0;
         out_valid_reg   <= 1'b0;
         out_last_reg    <= 1'b0;
         replay_done_reg <= 1'b1;
         underrun_reg    <= 1'b0;
      end else if (new_frame) begin
         // Restart from the list just captured; an unfinished replay is lost.
         // A final transfer on this very edge still counts as delivered.
         rd_len_reg      <= wr_count_reg;
         rd_ptr_reg      <= '0;
         out_valid_reg   <= 1'b0;
         out_last_reg    <= 1'b0;
         replay_done_reg <= (wr_count_reg == '0);
         state_reg       <= (wr_count_reg != '0) ? ST_FETCH : ST_IDLE;
         if ((state_reg == ST_FETCH) ||
             ((state_reg == ST_PRESENT) && !(xfer && at_last))) begin
            underrun_reg <= 1'b1;
         end
      end else begin
         case (state_reg)
            ST_FETCH: begin
               state_reg     <= ST_PRESENT;
               out_valid_reg <= 1'b1;
               out_last_reg  <= at_last;
            end
            ST_PRESENT: begin
               if (xfer) begin
                  if (at_last) begin
                     state_reg       <= ST_IDLE;
                     out_valid_reg   <= 1'b0;
                     out_last_reg    <= 1'b0;
                     replay_done_reg <= 1'b1;
                  end else begin
                     rd_ptr_reg   <= rd_ptr_reg + CW'(1);
                     out_last_reg <= (rd_ptr_reg + CW'(1) == rd_len_reg - CW'(1));
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign {out_x, out_y, out_frame} = rd_data_reg;
   assign out_valid   = out_valid_reg;
   assign out_last    = out_last_reg;
   assign wr_count    = wr_count_reg;
   assign replay_done = replay_done_reg;
   assign overflow    = overflow_reg;
   assign underrun    = underrun_reg;

endmodule

// File: tb/tb_sprite_list_buffer.sv
// tb_sprite_list_buffer
//   Table-driven check of the sprite list buffer (default parameters), plus
//   hand-written sequences for overflow, stalled-replay underrun and reset
//   during replay. Inputs change and outputs are sampled on the falling edge.
module tb_sprite_list_buffer;

   localparam int XW = $clog2(360);
   localparam int YW = $clog2(720);
   localparam int FW = $clog2(5);
   localparam int CW = $clog2(64 + 1);

   logic          clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          new_frame = 1'b0;
   logic          in_valid = 1'b0;
   logic [XW-1:0] in_x = '0;
   logic [YW-1:0] in_y = '0;
   logic [FW-1:0] in_frame = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic [FW-1:0] out_frame;
   logic          out_last;
   logic [CW-1:0] wr_count;
   logic          replay_done;
   logic          overflow;
   logic          underrun;

   int checks = 0;
   int failures = 0;

   sprite_list_buffer dut (
      .clk_pixel   (clk),
      .sys_rst_n   (sys_rst_n),
      .new_frame   (new_frame),
      .in_valid    (in_valid),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_frame    (in_frame),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_frame   (out_frame),
      .out_last    (out_last),
      .wr_count    (wr_count),
      .replay_done (replay_done),
      .overflow    (overflow),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit nf;  bit iv;  int x;  int y;  int f;  bit rdy;
      bit e_valid; bit e_last; int e_x; int e_y; int e_f; int e_wc; bit e_done;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit nf, bit iv, int x, int y, int f, bit rdy,
                               bit ev, bit el, int ex, int ey, int ef, int ewc, bit ed);
      vec_t v;
      v.nf = nf; v.iv = iv; v.x = x; v.y = y; v.f = f; v.rdy = rdy;
      v.e_valid = ev; v.e_last = el; v.e_x = ex; v.e_y = ey; v.e_f = ef;
      v.e_wc = ewc; v.e_done = ed;
      return v;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_out_valid"},   32'(out_valid),   0);
      chk({tag, "_out_last"},    32'(out_last),    0);
      chk({tag, "_out_x"},       32'(out_x),       0);
      chk({tag, "_out_y"},       32'(out_y),       0);
      chk({tag, "_out_frame"},   32'(out_frame),   0);
      chk({tag, "_wr_count"},    32'(wr_count),    0);
      chk({tag, "_replay_done"}, 32'(replay_done), 1);
      chk({tag, "_overflow"},    32'(overflow),    0);
      chk({tag, "_underrun"},    32'(underrun),    0);
   endtask

   // n writes on consecutive cycles: x = xb+i, y = yb+i, frame = i%5
   task automatic write_seq(input int n, input int xb, input int yb);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_x = XW'(xb + i);
         in_y = YW'(yb + i);
         in_frame = FW'(i % 5);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_nf();
      new_frame = 1'b1;
      @(negedge clk);
      new_frame = 1'b0;
   endtask

   // Collect a replay with out_ready held high; expects the write_seq pattern.
   task automatic drain_check(input string tag, input int n_exp, input int xb, input int yb);
      int n = 0;
      bit done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         if (out_valid) begin
            $display("%s: entry %0d x=%0d y=%0d f=%0d last=%0d", tag, n, out_x, out_y,
                     out_frame, out_last);
            chk({tag, "_x"},    32'(out_x),     32'(xb + n));
            chk({tag, "_y"},    32'(out_y),     32'(yb + n));
            chk({tag, "_f"},    32'(out_frame), 32'(n % 5));
            chk({tag, "_last"}, 32'(out_last),  32'(n == n_exp - 1));
            n++;
         end
         if (n > 0 && !out_valid && replay_done) done = 1'b1;
         else @(negedge clk);
      end
      chk({tag, "_count"}, 32'(n), 32'(n_exp));
      chk({tag, "_done"},  32'(done), 1);
   endtask

   initial begin
      // --- vector table ---
      // empty frame
      vecs.push_back(mk(1,0, 0, 0,0,0, 0,0, 0, 0,0, 0,1));
      vecs.push_back(mk(0,0, 0, 0,0,0, 0,0, 0, 0,0, 0,1));
      // three sprites, replay at full rate
      vecs.push_back(mk(0,1,10,20,1,0, 0,0, 0, 0,0, 1,1));
      vecs.push_back(mk(0,1,11,21,2,0, 0,0, 0, 0,0, 2,1));
      vecs.push_back(mk(0,1,12,22,3,0, 0,0, 0, 0,0, 3,1));
      vecs.push_back(mk(1,0, 0, 0,0,1, 0,0, 0, 0,0, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 1,0,10,20,1, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 1,0,11,21,2, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 1,1,12,22,3, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 0,0, 0, 0,0, 0,1));
      // write coincident with new_frame lands at index 0
      vecs.push_back(mk(1,1, 7, 8,4,1, 0,0, 0, 0,0, 1,1));
      vecs.push_back(mk(0,0, 0, 0,0,1, 0,0, 0, 0,0, 1,1));
      vecs.push_back(mk(1,0, 0, 0,0,1, 0,0, 0, 0,0, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 1,1, 7, 8,4, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 0,0, 0, 0,0, 0,1));
      // four entries, out_ready pattern 1,0,0,1,...
      vecs.push_back(mk(0,1,30,40,0,0, 0,0, 0, 0,0, 1,1));
      vecs.push_back(mk(0,1,31,41,1,0, 0,0, 0, 0,0, 2,1));
      vecs.push_back(mk(0,1,32,42,2,0, 0,0, 0, 0,0, 3,1));
      vecs.push_back(mk(0,1,33,43,3,0, 0,0, 0, 0,0, 4,1));
      vecs.push_back(mk(1,0, 0, 0,0,0, 0,0, 0, 0,0, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 1,0,30,40,0, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 1,0,31,41,1, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,0, 1,0,31,41,1, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,0, 1,0,31,41,1, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 1,0,32,42,2, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,0, 1,0,32,42,2, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,0, 1,0,32,42,2, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 1,1,33,43,3, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,0, 1,1,33,43,3, 0,0));
      vecs.push_back(mk(0,0, 0, 0,0,1, 0,0, 0, 0,0, 0,1));

      // --- reset ---
      repeat (3) @(negedge clk);
      sys_rst_n = 1'b1;
      check_reset("reset");

      // --- apply table ---
      for (int i = 0; i < vecs.size(); i++) begin
         new_frame = vecs[i].nf;
         in_valid  = vecs[i].iv;
         in_x      = XW'(vecs[i].x);
         in_y      = YW'(vecs[i].y);
         in_frame  = FW'(vecs[i].f);
         out_ready = vecs[i].rdy;
         @(negedge clk);
         $display("vec %0d: valid=%0d last=%0d x=%0d y=%0d f=%0d wc=%0d done=%0d", i,
                  out_valid, out_last, out_x, out_y, out_frame, wr_count, replay_done);
         chk($sformatf("vec%0d_valid", i), 32'(out_valid),   32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_last", i),  32'(out_last),    32'(vecs[i].e_last));
         chk($sformatf("vec%0d_wc", i),    32'(wr_count),    32'(vecs[i].e_wc));
         chk($sformatf("vec%0d_done", i),  32'(replay_done), 32'(vecs[i].e_done));
         chk($sformatf("vec%0d_ovf", i),   32'(overflow),    0);
         chk($sformatf("vec%0d_unr", i),   32'(underrun),    0);
         if (vecs[i].e_valid) begin
            chk($sformatf("vec%0d_x", i), 32'(out_x),     32'(vecs[i].e_x));
            chk($sformatf("vec%0d_y", i), 32'(out_y),     32'(vecs[i].e_y));
            chk($sformatf("vec%0d_f", i), 32'(out_frame), 32'(vecs[i].e_f));
         end
      end
      new_frame = 1'b0;
      in_valid  = 1'b0;

      // --- overflow: 65 writes into a 64-entry bank ---
      write_seq(64, 0, 100);
      $display("ovf: after 64 writes wc=%0d overflow=%0d", wr_count, overflow);
      chk("ovf_wc64", 32'(wr_count), 64);
      chk("ovf_flag_clear", 32'(overflow), 0);
      write_seq(1, 99, 99);
      $display("ovf: after 65th write wc=%0d overflow=%0d", wr_count, overflow);
      chk("ovf_wc_hold", 32'(wr_count), 64);
      chk("ovf_flag_set", 32'(overflow), 1);
      out_ready = 1'b1;
      pulse_nf();
      chk("ovf_flag_nf", 32'(overflow), 0);
      chk("ovf_wc_nf", 32'(wr_count), 0);
      drain_check("ovf_replay", 64, 0, 100);

      // --- underrun: stalled 5-entry replay overtaken by a 2-entry frame ---
      out_ready = 1'b0;
      write_seq(5, 50, 0);
      pulse_nf();
      write_seq(2, 60, 70);
      @(negedge clk);
      $display("unr: stalled valid=%0d x=%0d", out_valid, out_x);
      chk("unr_stall_valid", 32'(out_valid), 1);
      chk("unr_stall_x0", 32'(out_x), 50);
      @(negedge clk);
      chk("unr_stall_x1", 32'(out_x), 50);
      chk("unr_before", 32'(underrun), 0);
      pulse_nf();
      $display("unr: after new_frame underrun=%0d valid=%0d", underrun, out_valid);
      chk("unr_set", 32'(underrun), 1);
      chk("unr_valid_drop", 32'(out_valid), 0);
      out_ready = 1'b1;
      drain_check("unr_replay", 2, 60, 70);
      chk("unr_sticky", 32'(underrun), 1);

      // --- reset in the middle of a replay ---
      write_seq(3, 1, 1);
      pulse_nf();
      @(negedge clk);
      sys_rst_n = 1'b0;
      @(negedge clk);
      $display("midrst: valid=%0d x=%0d done=%0d underrun=%0d", out_valid, out_x,
               replay_done, underrun);
      check_reset("midrst");
      sys_rst_n = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_list_buffer.md
# sprite_list_buffer

Double-buffered sprite list between the sprite processor and the graphics stage. During video frame N it collects the processor's sprite stream: one sprite per valid cycle, with no backpressure. At the following `new_frame` pulse it swaps banks and replays the captured list to the graphics sprite port using a valid/ready handshake. This decouples the processor's bursty emission from the renderer's pace and ensures graphics always sees one complete, stable list per frame.

## Interface

**Parameters**
- `CANVAS_WIDTH`, default 360: x range; `XW = $clog2(CANVAS_WIDTH)`.
- `CANVAS_HEIGHT`, default 720: y range; `YW = $clog2(CANVAS_HEIGHT)`.
- `NUM_FRAMES`, default 5: sprite animation frames; `FW = $clog2(NUM_FRAMES)`.
- `MAX_SPRITES`, default 64: entries per bank; `CW = $clog2(MAX_SPRITES+1)`.

**Ports**
- `clk_pixel`, in, 1: pixel clock; the only clock.
- `sys_rst_n`, in, 1: reset, synchronous, active-low.
- `new_frame`, in, 1: one-cycle pulse from the video signal generator.
- `in_valid`, in, 1: processor sprite strobe.
- `in_x`, in, XW: sprite x coordinate.
- `in_y`, in, YW: sprite y coordinate.
- `in_frame`, in, FW: sprite animation frame number.
- `out_valid`, out, 1: replay entry available.
- `out_ready`, in, 1: graphics accepts the entry.
- `out_x`, out, XW; `out_y`, out, YW; `out_frame`, out, FW: replayed entry.
- `out_last`, out, 1: qualifies the final entry of the list.
- `wr_count`, out, CW: entries captured so far this frame.
- `replay_done`, out, 1: read bank fully drained.
- `overflow`, out, 1: at least one write dropped this collection frame.
- `underrun`, out, 1: sticky; a replay was cut short by `new_frame`.

## Operation

- Storage: two banks (A and B) of `MAX_SPRITES` entries, each `XW+YW+FW` bits wide. `wsel` selects the write bank; the read bank is `!wsel`. Inferred as BRAM/LUTRAM with 1-cycle read.
- Collection: when `in_valid` is high and `wr_count < MAX_SPRITES`, write `{in_x,in_y,in_frame}` to `bank[wsel][wr_count]` and increment `wr_count`.
- Full: when `in_valid` is high and `wr_count == MAX_SPRITES`, the entry is dropped, `overflow` is set, and `wr_count` holds.
- On `new_frame`:
  - `wsel` toggles.
  - `rd_len <= wr_count`; `rd_ptr <= 0`.
  - `wr_count <= 0`; `overflow <= 0`.
  - Any in-flight replay is abandoned.
- Replay FSM with states IDLE, FETCH, PRESENT:
  - IDLE: `out_valid = 0`. On `new_frame`, go to FETCH if the latched `rd_len > 0`; otherwise stay in IDLE with `replay_done = 1`.
  - FETCH: issue a read of `rd_ptr`, then go to PRESENT.
  - PRESENT: `out_valid = 1`. On `out_valid && out_ready`:
    - If `rd_ptr == rd_len-1`: go to IDLE and set `replay_done`.
    - Otherwise: advance `rd_ptr` and continue.
  - Sustained throughput is 1 entry/cycle while `out_ready` stays high. Prefetching or a skid register is required so that FETCH bubbles occur only at list start.
- `out_last = out_valid && (current entry index == rd_len-1)`.
- `new_frame` in any state: restart from the new `rd_len`. If it arrives in FETCH/PRESENT with entries still undelivered, set `underrun`.
- `replay_done` clears on `new_frame` when the new `rd_len > 0`.
- `in_valid` coincident with `new_frame`: the entry goes to index 0 of the newly selected write bank; `wr_count` becomes 1.

## Timing

- Reset values:
  - `out_valid`, `out_last`, `out_x`, `out_y`, `out_frame`: 0.
  - `wr_count`, `rd_len`, `rd_ptr`, `overflow`, `underrun`: 0.
  - `replay_done` = 1; `wsel` = 0 (bank A is the write bank).
  - Reset mid-replay aborts immediately on the next edge; bank contents are don't-care.
- Latency: with `new_frame` at edge T, first `out_valid` is high at edge T+2 (FETCH at T+1).
- Handshake:
  - A transfer occurs on a rising edge with `out_valid && out_ready`.
  - While `out_valid && !out_ready`, `out_x`, `out_y`, `out_frame`, and `out_last` hold stable.
  - `out_valid` never drops without a transfer, except on `new_frame` or reset.
- `wr_count` updates the edge after the accepted write.
- `overflow` sets the edge after the first dropped write.
- All outputs are registered; no combinational path from `out_ready` to `out_valid`.

## Test plan

- Reset, then `new_frame` with nothing captured -> `out_valid` stays 0, `replay_done` = 1, `underrun` = 0.
- Write 3 sprites (x=10,y=20,f=1; x=11,y=21,f=2; x=12,y=22,f=3), then `new_frame` with `out_ready` held high -> `out_valid` at T+2, three consecutive transfers in order, `out_last` only on x=12, then `replay_done` = 1.
- Write 65 sprites with `MAX_SPRITES`=64 -> `wr_count` = 64, `overflow` = 1 after the 65th. Next `new_frame` -> `overflow` = 0 and exactly 64 entries replayed.
- 4-entry list with `out_ready` toggling 1,0,0,1,… -> outputs stable during stalls, 4 transfers, no duplicates or losses.
- 5-entry list, `out_ready` = 0 throughout, second `new_frame` carrying a 2-entry list -> `underrun` = 1 and only the 2 new entries appear.
- `in_valid` coincident with `new_frame` (x=7) -> `wr_count` = 1; after the next `new_frame`, the first replayed entry has x=7.
